// File: rtl/serial_adder.sv
// Bit-serial ripple adder: {Co, S} = A + B + Ci, one bit per clock, LSB first.
// Three-state control (IDLE/ADD/DONE) with registered result held between operations.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_co;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_sbit;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum_next;

    // start is only honoured when no addition is in flight
    assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last     = (r_state == ADD) && (r_cnt == CW'(WIDTH - 1));
    assign w_sbit     = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cout     = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_sum_next = {w_sbit, r_sum[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? ADD : IDLE;
            ADD:     w_next = w_last ? DONE : ADD;
            DONE:    w_next = start ? ADD : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ADD:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            r_s   <= '0;
            r_co  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_c   <= Ci;
            r_cnt <= '0;
        end else if (r_state == ADD) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_sum <= w_sum_next;
            r_c   <= w_cout;
            r_cnt <= r_cnt + CW'(1);
            // result registers change only on entry to DONE
            if (w_last) begin
                r_s  <= w_sum_next;
                r_co <= w_cout;
            end
        end
    end

    assign S  = r_s;
    assign Co = r_co;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=4).
// Inputs driven and outputs sampled on the falling edge.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Ci;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Co;

    int tests;
    int fails;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Co    (Co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // From the current falling edge, count busy cycles until done is seen.
    task automatic wait_done(output int nbusy, output int overlap, output bit ok);
        nbusy   = 0;
        overlap = 0;
        ok      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy && done) overlap++;
            if (done) begin
                ok = 1'b1;
                return;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          output int nbusy, output int overlap, output bit ok);
        start = 1'b1; A = a; B = b; Ci = ci;
        @(negedge clk);
        start = 1'b0;
        wait_done(nbusy, overlap, ok);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; A = 4'hF; B = 4'hF; Ci = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({busy, done, S, Co} !== 7'b0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b S=%0d Co=%b, required all 0", busy, done, S, Co);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_priority: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_zero();
        int nb, ov; bit ok;
        run_op(4'd0, 4'd0, 1'b0, nb, ov, ok);
        tests++;
        if (!ok || nb !== 4 || ov !== 0) begin
            fails++;
            $display("FAIL zero_latency: done_seen=%b busy_cycles=%0d overlap=%0d, required 1/4/0", ok, nb, ov);
        end
        tests++;
        if (S !== 4'd0 || Co !== 1'b0) begin
            fails++;
            $display("FAIL zero_result: S=%0d Co=%b, required S=0 Co=0", S, Co);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: busy=%b done=%b after done, required 0/0", busy, done);
        end
    endtask

    task automatic test_basic();
        int nb, ov; bit ok;
        run_op(4'd15, 4'd1, 1'b0, nb, ov, ok);
        tests++;
        if (!ok || S !== 4'd0 || Co !== 1'b1) begin
            fails++;
            $display("FAIL add_15_1_0: done_seen=%b S=%0d Co=%b, required S=0 Co=1", ok, S, Co);
        end
        @(negedge clk);
        run_op(4'd9, 4'd5, 1'b1, nb, ov, ok);
        tests++;
        if (!ok || nb !== 4 || S !== 4'd15 || Co !== 1'b0) begin
            fails++;
            $display("FAIL add_9_5_1: done_seen=%b busy=%0d S=%0d Co=%b, required busy=4 S=15 Co=0", ok, nb, S, Co);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        int nb, ov; bit ok;
        int bad;
        run_op(4'd7, 4'd8, 1'b1, nb, ov, ok);
        tests++;
        if (!ok || S !== 4'd0 || Co !== 1'b1) begin
            fails++;
            $display("FAIL add_7_8_1: done_seen=%b S=%0d Co=%b, required S=0 Co=1", ok, S, Co);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (S !== 4'd0 || Co !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL idle_hold: %0d bad idle cycles (last S=%0d Co=%b), required 0", bad, S, Co);
        end
    endtask

    task automatic test_start_during_busy();
        int ndone, holderr;
        logic [W-1:0] s_cap;
        logic         co_cap;
        ndone = 0; holderr = 0; s_cap = '0; co_cap = 1'b0;
        start = 1'b1; A = 4'd3; B = 4'd4; Ci = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; A = 4'd1; B = 4'd1; Ci = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                ndone++;
                s_cap  = S;
                co_cap = Co;
            end else if (busy && (S !== 4'd0 || Co !== 1'b1)) begin
                holderr++;
            end
            @(negedge clk);
        end
        tests++;
        if (ndone !== 1 || s_cap !== 4'd7 || co_cap !== 1'b0) begin
            fails++;
            $display("FAIL start_in_busy: done_count=%0d S=%0d Co=%b, required 1 done S=7 Co=0", ndone, s_cap, co_cap);
        end
        tests++;
        if (holderr !== 0) begin
            fails++;
            $display("FAIL hold_in_add: %0d cycles result changed during ADD, required 0", holderr);
        end
    endtask

    task automatic test_back_to_back();
        int nb, ov; bit ok;
        run_op(4'd2, 4'd2, 1'b0, nb, ov, ok);
        tests++;
        if (!ok || S !== 4'd4 || Co !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first: done_seen=%b S=%0d Co=%b, required S=4 Co=0", ok, S, Co);
        end
        start = 1'b1; A = 4'd10; B = 4'd6; Ci = 1'b0;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || S !== 4'd4) begin
            fails++;
            $display("FAIL b2b_turnaround: busy=%b done=%b S=%0d, required busy=1 done=0 S=4", busy, done, S);
        end
        wait_done(nb, ov, ok);
        tests++;
        if (!ok || nb !== 4 || ov !== 0 || S !== 4'd0 || Co !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second: done_seen=%b busy=%0d S=%0d Co=%b, required busy=4 S=0 Co=1", ok, nb, S, Co);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_add();
        int nb, ov, ndone; bit ok;
        start = 1'b1; A = 4'd15; B = 4'd15; Ci = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || S !== 4'd0 || Co !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_add: busy=%b done=%b S=%0d Co=%b, required all 0", busy, done, S, Co);
        end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        tests++;
        if (ndone !== 0) begin
            fails++;
            $display("FAIL abort_quiet: %0d busy/done cycles after abort, required 0", ndone);
        end
        run_op(4'd1, 4'd1, 1'b0, nb, ov, ok);
        tests++;
        if (!ok || nb !== 4 || S !== 4'd2 || Co !== 1'b0) begin
            fails++;
            $display("FAIL after_abort: done_seen=%b busy=%0d S=%0d Co=%b, required busy=4 S=2 Co=0", ok, nb, S, Co);
        end
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Ci = 1'b0;
        @(negedge clk);
        test_reset();
        test_zero();
        test_basic();
        test_hold();
        test_start_during_busy();
        test_back_to_back();
        test_reset_mid_add();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
